video_pattern_gen: RTL



---
 rtl/video_pkg.sv | 35 +++
 rtl/video_pattern_gen.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/video_pkg.sv
// Shared types and pixel function for the video test-pattern source and its consumers.
package video_pkg;

    typedef enum logic [1:0] {
        PAT_HRAMP = 2'd0,
        PAT_VRAMP = 2'd1,
        PAT_CHECK = 2'd2,
        PAT_COUNT = 2'd3
    } pattern_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        HBLANK = 2'd2,
        VBLANK = 2'd3
    } state_e;

    // Full-width pixel value; callers truncate to their pixel width.
    function automatic logic [31:0] pixel_value(
        input pattern_e    pat,
        input logic [31:0] x,
        input logic [31:0] y,
        input logic [31:0] f
    );
        logic [31:0] v;
        case (pat)
            PAT_HRAMP: v = x;
            PAT_VRAMP: v = y;
            PAT_CHECK: v = (x[1] ^ y[1]) ? '1 : '0;
            default:   v = x + y + f;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/video_pattern_gen.sv
// AXI4-Stream-style video test-pattern source with backpressure and optional blanking.
module video_pattern_gen
    import video_pkg::*;
#(
    parameter int unsigned D_WIDTH  = 8,
    parameter int unsigned H_ACTIVE = 16,
    parameter int unsigned V_ACTIVE = 8,
    parameter int unsigned H_GAP    = 0,
    parameter int unsigned V_GAP    = 0,
    parameter int unsigned FC_WIDTH = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [1:0]          pattern,
    output logic [D_WIDTH-1:0]  down_data,
    output logic                down_valid,
    output logic                down_tlast,
    output logic                down_tuser,
    input  logic                down_ready,
    output logic [FC_WIDTH-1:0] frame_cnt
);

    localparam int unsigned XW      = $clog2(H_ACTIVE);
    localparam int unsigned YW      = $clog2(V_ACTIVE);
    localparam int unsigned GAP_MAX = (H_GAP > V_GAP) ? H_GAP : V_GAP;
    localparam int unsigned GAP_W   = (GAP_MAX > 1) ? $clog2(GAP_MAX) : 1;

    state_e              state_q, state_d;
    pattern_e            pat_q, pat_d;
    logic [XW-1:0]       x_q, x_d;
    logic [YW-1:0]       y_q, y_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic [FC_WIDTH-1:0] fcnt_q, fcnt_d;
    logic [D_WIDTH-1:0]  data_q, data_d;
    logic                valid_q, valid_d;
    logic                tlast_q, tlast_d;
    logic                tuser_q, tuser_d;
    logic                frame_start;
    logic                present;

    // State register and output stage
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pat_q   <= PAT_HRAMP;
            x_q     <= '0;
            y_q     <= '0;
            gap_q   <= '0;
            fcnt_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            tlast_q <= 1'b0;
            tuser_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            x_q     <= x_d;
            y_q     <= y_d;
            gap_q   <= gap_d;
            fcnt_q  <= fcnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            tlast_q <= tlast_d;
            tuser_q <= tuser_d;
        end
    end

    // Next-state: x/y always point at the pixel being presented (or the next one during blanking)
    always_comb begin
        state_d     = state_q;
        pat_d       = pat_q;
        x_d         = x_q;
        y_d         = y_q;
        gap_d       = gap_q;
        fcnt_d      = fcnt_q;
        data_d      = data_q;
        valid_d     = valid_q;
        tlast_d     = tlast_q;
        tuser_d     = tuser_q;
        frame_start = 1'b0;
        present     = 1'b0;

        case (state_q)
            IDLE: begin
                if (enable) frame_start = 1'b1;
            end
            ACTIVE: begin
                if (valid_q && down_ready) begin
                    if (x_q != XW'(H_ACTIVE - 1)) begin
                        x_d     = x_q + XW'(1);
                        present = 1'b1;
                    end else begin
                        x_d = '0;
                        if (y_q != YW'(V_ACTIVE - 1)) begin
                            y_d = y_q + YW'(1);
                            if (H_GAP == 0) begin
                                present = 1'b1;
                            end else begin
                                valid_d = 1'b0;
                                gap_d   = GAP_W'(H_GAP - 1);
                                state_d = HBLANK;
                            end
                        end else begin
                            y_d    = '0;
                            fcnt_d = fcnt_q + FC_WIDTH'(1);
                            if (V_GAP == 0) begin
                                frame_start = 1'b1;
                            end else begin
                                valid_d = 1'b0;
                                gap_d   = GAP_W'(V_GAP - 1);
                                state_d = VBLANK;
                            end
                        end
                    end
                end
            end
            HBLANK: begin
                if (gap_q == '0) begin
                    state_d = ACTIVE;
                    present = 1'b1;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            VBLANK: begin
                if (gap_q == '0) frame_start = 1'b1;
                else             gap_d = gap_q - GAP_W'(1);
            end
            default: state_d = IDLE;
        endcase

        // Enable and pattern are only honoured at frame boundaries
        if (frame_start) begin
            if (enable) begin
                state_d = ACTIVE;
                pat_d   = pattern_e'(pattern);
                x_d     = '0;
                y_d     = '0;
                present = 1'b1;
            end else begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        end

        if (present) begin
            valid_d = 1'b1;
            data_d  = D_WIDTH'(pixel_value(pat_d, 32'(x_d), 32'(y_d), 32'(fcnt_d)));
            tlast_d = (x_d == XW'(H_ACTIVE - 1));
            tuser_d = (x_d == '0) && (y_d == '0);
        end
    end

    assign down_data  = data_q;
    assign down_valid = valid_q;
    assign down_tlast = tlast_q;
    assign down_tuser = tuser_q;
    assign frame_cnt  = fcnt_q;

endmodule
